// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit bus computer: T-state counter plus {opcode, step, flags} decode.
// Optional EARLY_END_EN returns to T0 right after an instruction's last active execute step.
module control_sequencer #(
  parameter int unsigned NUM_STEPS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        flag_carry,
  input  logic        flag_zero,
  output logic [15:0] ctrl,
  output logic [2:0]  tstate
);

  localparam logic [15:0] Halt      = 16'h8000;
  localparam logic [15:0] MarLoad   = 16'h4000;
  localparam logic [15:0] RamLoad   = 16'h2000;
  localparam logic [15:0] RamOut    = 16'h1000;
  localparam logic [15:0] IrLoad    = 16'h0800;
  localparam logic [15:0] IrOut     = 16'h0400;
  localparam logic [15:0] ALoad     = 16'h0200;
  localparam logic [15:0] AOut      = 16'h0100;
  localparam logic [15:0] AluOut    = 16'h0080;
  localparam logic [15:0] AluSub    = 16'h0040;
  localparam logic [15:0] BLoad     = 16'h0020;
  localparam logic [15:0] OutLoad   = 16'h0010;
  localparam logic [15:0] PcInc     = 16'h0008;
  localparam logic [15:0] PcOut     = 16'h0004;
  localparam logic [15:0] PcLoad    = 16'h0002;
  localparam logic [15:0] FlagsLoad = 16'h0001;

  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [2:0] LastStep = 3'(NUM_STEPS - 1);

  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [15:0] word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

`ifdef EARLY_END_EN
  logic [2:0] last_step;

  always_comb begin
    unique case (opcode)
      OpLda, OpSta: last_step = 3'd3;
      OpAdd, OpSub: last_step = 3'd4;
      default:      last_step = 3'd2;
    endcase
  end
`endif

  // Halted freezes the step at T2 and ignores run; HLT latches on the T2 edge.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q && run) begin
      if (step_q == 3'd2 && opcode == OpHlt) begin
        halted_d = 1'b1;
      end else if (step_q == LastStep) begin
        step_d = 3'd0;
`ifdef EARLY_END_EN
      end else if (step_q >= 3'd2 && step_q == last_step) begin
        step_d = 3'd0;
`endif
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  // Flags only matter in T2, where the conditional jumps decide.
  always_comb begin
    word = 16'h0;
    case (step_q)
      3'd0: word = PcOut | MarLoad;
      3'd1: word = RamOut | IrLoad | PcInc;
      3'd2: begin
        case (opcode)
          OpLda, OpAdd, OpSub, OpSta: word = IrOut | MarLoad;
          OpLdi: word = IrOut | ALoad;
          OpJmp: word = IrOut | PcLoad;
          OpJc:  word = flag_carry ? (IrOut | PcLoad) : 16'h0;
          OpJz:  word = flag_zero  ? (IrOut | PcLoad) : 16'h0;
          OpOut: word = AOut | OutLoad;
          OpHlt: word = Halt;
          default: word = 16'h0;
        endcase
      end
      3'd3: begin
        case (opcode)
          OpLda:        word = RamOut | ALoad;
          OpAdd, OpSub: word = RamOut | BLoad;
          OpSta:        word = AOut | RamLoad;
          default:      word = 16'h0;
        endcase
      end
      3'd4: begin
        case (opcode)
          OpAdd:   word = AluOut | ALoad | FlagsLoad;
          OpSub:   word = AluOut | AluSub | ALoad | FlagsLoad;
          default: word = 16'h0;
        endcase
      end
      default: word = 16'h0;
    endcase
  end

  always_comb begin
    ctrl = 16'h0;
    if (!rst_n) begin
      ctrl = 16'h0;
    end else if (halted_q) begin
      ctrl = Halt;
    end else if (run) begin
      ctrl = word;
    end
  end

  assign tstate = step_q;

endmodule
